// File: rtl/button_pkg.sv
// Shared event-code definitions for the button event path: debouncer users,
// the scheduler and downstream consumers all agree on these encodings.
package button_pkg;

  typedef enum logic [1:0] {
    PRESS   = 2'd0,
    RELEASE = 2'd1,
    LONG    = 2'd2
  } evt_code_e;

  localparam int EVT_ID_W = 3;

  // Index successor with wrap-around, used to rotate the round-robin pointer.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority search: first requester at or after ptr wins.
// Purely combinational; the caller owns and advances the pointer.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // NOTE: every output gets a default before the loop so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    int cand;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/button_event_scheduler.sv
// Collects press/release/long-press events from debounced buttons, merges
// repeats per button, and presents them one at a time on a valid/ready port.
module button_event_scheduler
  import button_pkg::*;
#(
  parameter int NUM_BTN    = 4,
  parameter int LONG_TICKS = 200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [NUM_BTN-1:0] btn_rising,
  input  logic [NUM_BTN-1:0] btn_falling,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [2:0]         evt_id,
  output logic [1:0]         evt_code,
  output logic               overflow
);

  localparam int IW = $clog2(NUM_BTN);
  localparam int CW = $clog2(LONG_TICKS + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(LONG_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(LONG_TICKS - 1);

  logic [NUM_BTN-1:0] pend_press, pend_rel, pend_long;
  logic [NUM_BTN-1:0] held;
  logic [CW-1:0]      hold_cnt [NUM_BTN];
  logic [IW-1:0]      rr_ptr;

  logic [NUM_BTN-1:0] long_set, req, grant;
  logic [NUM_BTN-1:0] clr_press, clr_rel, clr_long;
  logic [IW-1:0]      win_idx;
  logic               win_any, load_en, do_load, ovf_next;
  evt_code_e          win_code;

  // Long fires on the tick that brings the counter to its ceiling; a
  // simultaneous edge pulse restarts the hold instead.
  always_comb begin
    long_set = '0;
    for (int i = 0; i < NUM_BTN; i++)
      long_set[i] = tick && held[i] && !btn_rising[i] && !btn_falling[i]
                    && (hold_cnt[i] == CNT_LAST);
  end

  assign req = pend_press | pend_rel | pend_long;

  rr_arbiter #(.N(NUM_BTN)) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  assign load_en = !evt_valid || evt_ready;
  assign do_load = load_en && win_any;

  always_comb begin
    win_code  = RELEASE;
    clr_press = '0;
    clr_rel   = '0;
    clr_long  = '0;
    if (|(grant & pend_press))     win_code = PRESS;
    else if (|(grant & pend_long)) win_code = LONG;
    if (do_load) begin
      unique case (win_code)
        PRESS:   clr_press = grant;
        LONG:    clr_long  = grant;
        default: clr_rel   = grant;
      endcase
    end
  end

  // A set landing on a bit being cleared this edge is a fresh event, not a merge.
  assign ovf_next = |((btn_rising  & pend_press & ~clr_press) |
                      (btn_falling & pend_rel   & ~clr_rel)   |
                      (long_set    & pend_long  & ~clr_long));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_press <= '0;
      pend_rel   <= '0;
      pend_long  <= '0;
      held       <= '0;
    end else begin
      pend_press <= (pend_press & ~clr_press) | btn_rising;
      pend_rel   <= (pend_rel   & ~clr_rel)   | btn_falling;
      pend_long  <= (pend_long  & ~clr_long)  | long_set;
      held       <= (held | btn_rising) & ~btn_falling;
    end
  end

  // NOTE: the hold counters are individual flops, not a RAM, so each one is
  // cleared by reset; a stale count would otherwise fake a long press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BTN; i++) hold_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (btn_rising[i] || btn_falling[i])
          hold_cnt[i] <= '0;
        else if (tick && held[i] && hold_cnt[i] != CNT_MAX)
          hold_cnt[i] <= hold_cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_code  <= '0;
      rr_ptr    <= '0;
      overflow  <= 1'b0;
    end else begin
      overflow <= ovf_next;
      if (do_load) begin
        evt_valid <= 1'b1;
        evt_id    <= 3'(win_idx);
        evt_code  <= win_code;
        rr_ptr    <= IW'(wrap_inc(int'(win_idx), NUM_BTN));
      end else if (load_en) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_button_event_scheduler.sv
// Scoreboard bench for button_event_scheduler: expected events are queued as
// stimulus is driven and compared whenever the DUT completes a handshake.
module tb_button_event_scheduler;
  import button_pkg::*;

  localparam int NUM_BTN    = 4;
  localparam int LONG_TICKS = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               tick;
  logic [NUM_BTN-1:0] btn_rising, btn_falling;
  logic               evt_valid, evt_ready, overflow;
  logic [2:0]         evt_id;
  logic [1:0]         evt_code;

  logic [4:0] exp_q [$];
  int n_vec = 0;
  int n_bad = 0;
  int ovf_cnt = 0;
  int ovf0;

  button_event_scheduler #(.NUM_BTN(NUM_BTN), .LONG_TICKS(LONG_TICKS)) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .btn_rising  (btn_rising),
    .btn_falling (btn_falling),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_id      (evt_id),
    .evt_code    (evt_code),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4:0] ev(input int id, input evt_code_e c);
    return {3'(id), 2'(c)};
  endfunction

  // Handshake monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (overflow) ovf_cnt++;
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) check("spurious", 32'({evt_id, evt_code}), 32'hFF);
        else                   check("evt", 32'({evt_id, evt_code}), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [NUM_BTN-1:0] r, input logic [NUM_BTN-1:0] f, input int len = 1);
    btn_rising  = r;
    btn_falling = f;
    cyc(len);
    btn_rising  = '0;
    btn_falling = '0;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      cyc(1);
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 50 && (exp_q.size() != 0 || evt_valid); i++) cyc(1);
    check(tag, 32'(exp_q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; tick = 1'b0; btn_rising = '0; btn_falling = '0; evt_ready = 1'b0;
    cyc(3);
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_id",    32'(evt_id),    0);
    check("rst_code",  32'(evt_code),  0);
    check("rst_ovf",   32'(overflow),  0);
    rst = 1'b0;
    evt_ready = 1'b1;
    cyc(2);

    // Simultaneous presses on 0,1,3 drain in id order, one per clk.
    exp_q.push_back(ev(0, PRESS));
    exp_q.push_back(ev(1, PRESS));
    exp_q.push_back(ev(3, PRESS));
    pulse(4'b1011, '0);
    check("multi_lat", 32'(evt_valid), 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      check("multi_b2b", 32'(evt_valid), 1);
    end
    cyc(1);
    check("multi_end", 32'(evt_valid), 0);
    // Pointer back at 0 means releases again come out 0,1,3.
    exp_q.push_back(ev(0, RELEASE));
    exp_q.push_back(ev(1, RELEASE));
    exp_q.push_back(ev(3, RELEASE));
    pulse('0, 4'b1011);
    drain("multi_drain");

    // Single press on button 2: valid two edges after the pulse, for one clk.
    exp_q.push_back(ev(2, PRESS));
    pulse(4'b0100, '0);
    check("b2_lat1", 32'(evt_valid), 0);
    cyc(1);
    check("b2_valid", 32'(evt_valid), 1);
    check("b2_id",    32'(evt_id),    2);
    check("b2_code",  32'(evt_code),  32'(PRESS));
    cyc(1);
    check("b2_once",  32'(evt_valid), 0);
    exp_q.push_back(ev(2, RELEASE));
    pulse('0, 4'b0100);
    drain("b2_drain");

    // Pointer now 3: presses on 0 and 3 wrap around, 3 first.
    exp_q.push_back(ev(3, PRESS));
    exp_q.push_back(ev(0, PRESS));
    pulse(4'b1001, '0);
    drain("wrap_press");
    exp_q.push_back(ev(3, RELEASE));
    exp_q.push_back(ev(0, RELEASE));
    pulse('0, 4'b1001);
    drain("wrap_rel");

    // Second press coinciding with load-clear stays pending, no overflow.
    ovf0 = ovf_cnt;
    exp_q.push_back(ev(2, PRESS));
    exp_q.push_back(ev(2, PRESS));
    pulse(4'b0100, '0, 2);
    drain("setwin_drain");
    check("setwin_ovf", 32'(ovf_cnt - ovf0), 0);
    exp_q.push_back(ev(2, RELEASE));
    pulse('0, 4'b0100);
    drain("setwin_rel");

    // Long press on button 1: exactly one long event after the 4th tick.
    exp_q.push_back(ev(1, PRESS));
    pulse(4'b0010, '0);
    drain("long_press");
    tick_n(LONG_TICKS - 1);
    cyc(3);
    check("long_early", 32'(evt_valid), 0);
    exp_q.push_back(ev(1, LONG));
    tick_n(1);
    drain("long_evt");
    tick_n(LONG_TICKS);
    cyc(3);
    exp_q.push_back(ev(1, RELEASE));
    pulse('0, 4'b0010);
    drain("long_rel");

    // Stalled consumer: output holds, repeat press merges with one overflow.
    evt_ready = 1'b0;
    exp_q.push_back(ev(1, PRESS));
    pulse(4'b0010, '0);
    cyc(2);
    check("stall_valid", 32'(evt_valid), 1);
    ovf0 = ovf_cnt;
    exp_q.push_back(ev(0, PRESS));
    pulse(4'b0001, '0);
    cyc(2);
    pulse(4'b0001, '0);
    cyc(2);
    check("stall_hold", 32'({evt_valid, evt_id, evt_code}), 32'({1'b1, 3'd1, 2'(PRESS)}));
    check("stall_ovf",  32'(ovf_cnt - ovf0), 1);
    evt_ready = 1'b1;
    drain("stall_drain");
    exp_q.push_back(ev(1, RELEASE));
    exp_q.push_back(ev(0, RELEASE));
    pulse('0, 4'b0011);
    drain("stall_rel");

    // Reset mid-hold and mid-handshake discards everything.
    evt_ready = 1'b0;
    exp_q.push_back(ev(2, PRESS));
    pulse(4'b0100, '0);
    cyc(2);
    check("rst_pre", 32'(evt_valid), 1);
    tick_n(2);
    rst = 1'b1;
    #1;
    check("rst_async_valid", 32'(evt_valid), 0);
    check("rst_async_out",   32'({evt_id, evt_code}), 0);
    exp_q.delete();
    cyc(2);
    rst = 1'b0;
    evt_ready = 1'b1;
    tick_n(2 * LONG_TICKS);
    cyc(5);
    check("rst_quiet", 32'(evt_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
